// File: rtl/cache_define.sv
// cache_define
// Shared configuration for the LLC tree-PLRU replacement controller.
// Holds the cache geometry, derived widths, the request opcode enum,
// the controller FSM state enum and the per-set PLRU tree type.
// No ports; imported by plru_tree_walk and plru_replacement_ctrl.
package cache_define;

  localparam int NUM_SETS  = 16384;
  localparam int WAYS      = 8;
  localparam int PLRU_BITS = WAYS - 1;
  localparam int SET_W     = $clog2(NUM_SETS);
  localparam int WAY_W     = $clog2(WAYS);

  typedef enum logic {
    PLRU_TOUCH  = 1'b0,
    PLRU_VICTIM = 1'b1
  } plru_op_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_UPDATE,
    ST_RESP
  } plru_state_e;

  typedef logic [PLRU_BITS-1:0] plru_tree_t;

endpackage

// File: rtl/plru_tree_walk.sv
// plru_tree_walk
// Purely combinational walk of one set's PLRU tree. Starting at node 0,
// one way bit is decided per level (MSB first); the decided bit is also
// written into the visited node, so the returned tree is ready to store.
// Ports:
//   tree       in   current PLRU bits of the set
//   op         in   PLRU_TOUCH follows 'way', PLRU_VICTIM follows cleared bits
//   way        in   way that was hit (TOUCH only)
//   new_tree   out  tree with every visited node updated
//   result_way out  TOUCH: echo of 'way'; VICTIM: chosen victim
module plru_tree_walk
  import cache_define::*;
(
  input  plru_tree_t       tree,
  input  plru_op_e         op,
  input  logic [WAY_W-1:0] way,
  output plru_tree_t       new_tree,
  output logic [WAY_W-1:0] result_way
);

  logic [WAY_W-1:0] node_idx;
  logic             dir_bit;

  // Heap-ordered tree: children of node n are 2n+1 (way bit 0) and
  // 2n+2 (way bit 1). The index computed after the last level is unused.
  always_comb begin
    new_tree   = tree;
    result_way = '0;
    node_idx   = '0;
    dir_bit    = 1'b0;
    for (int i = WAY_W - 1; i >= 0; i--) begin
      if (op == PLRU_VICTIM) begin
        dir_bit = ~tree[node_idx];
      end else begin
        dir_bit = way[i];
      end
      result_way[i]      = dir_bit;
      new_tree[node_idx] = dir_bit;
      node_idx = WAY_W'((32'(node_idx) << 1) + 32'd1 + 32'(dir_bit));
    end
  end

endmodule

// File: rtl/plru_replacement_ctrl.sv
// plru_replacement_ctrl
// Owns the tree-PLRU state of every LLC set and serialises TOUCH / VICTIM
// requests as a read-modify-write: IDLE -> READ -> UPDATE -> RESP. After
// reset the state array is swept to all-zero before requests are accepted.
// Optional build macro: PLRU_STATS_EN adds saturating 32-bit per-op
// completion counters.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready request handshake
//   req_op          0=TOUCH, 1=VICTIM
//   req_set         target set index
//   req_way         way hit (TOUCH only)
//   rsp_valid/ready response handshake
//   rsp_way         TOUCH: echoed way; VICTIM: chosen victim
//   init_done       high once the post-reset sweep completes
//   stat_touch_cnt  completed TOUCH count (PLRU_STATS_EN only)
//   stat_victim_cnt completed VICTIM count (PLRU_STATS_EN only)
module plru_replacement_ctrl
  import cache_define::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [SET_W-1:0] req_set,
  input  logic [WAY_W-1:0] req_way,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WAY_W-1:0] rsp_way,
`ifdef PLRU_STATS_EN
  output logic [31:0]      stat_touch_cnt,
  output logic [31:0]      stat_victim_cnt,
`endif
  output logic             init_done
);

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

  plru_state_e      state;
  plru_state_e      state_next;
  logic [SET_W-1:0] init_ptr;
  plru_op_e         cap_op;
  logic [SET_W-1:0] cap_set;
  logic [WAY_W-1:0] cap_way;
  plru_tree_t       rd_tree;
  plru_tree_t       walk_tree;
  logic [WAY_W-1:0] walk_way;
  logic             mem_we;
  logic [SET_W-1:0] mem_waddr;
  plru_tree_t       mem_wdata;

  plru_tree_t plru_mem [NUM_SETS];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:   if (init_ptr == LAST_SET) state_next = ST_IDLE;
      ST_IDLE:   if (req_valid)            state_next = ST_READ;
      ST_READ:                             state_next = ST_UPDATE;
      ST_UPDATE:                           state_next = ST_RESP;
      ST_RESP:   if (rsp_ready)            state_next = ST_IDLE;
      default:                             state_next = ST_INIT;
    endcase
  end

  // Outputs and array write port; the sweep and the write-back share it.
  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    mem_we    = 1'b0;
    mem_waddr = cap_set;
    mem_wdata = walk_tree;
    if (state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_ptr;
      mem_wdata = '0;
    end else if (state == ST_UPDATE) begin
      mem_we = 1'b1;
    end
  end

  // Sweep pointer, request capture and the registered response way.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_ptr  <= '0;
      init_done <= 1'b0;
      cap_op    <= PLRU_TOUCH;
      cap_set   <= '0;
      cap_way   <= '0;
      rsp_way   <= '0;
    end else begin
      if (state == ST_INIT) begin
        init_ptr <= init_ptr + 1'b1;
        if (init_ptr == LAST_SET) init_done <= 1'b1;
      end
      if (req_valid && req_ready) begin
        cap_op  <= plru_op_e'(req_op);
        cap_set <= req_set;
        cap_way <= req_way;
      end
      if (state == ST_UPDATE) rsp_way <= walk_way;
    end
  end

  // State array: one write and one registered read per cycle. The read
  // address is the captured set, so rd_tree is valid during UPDATE.
  always_ff @(posedge clk) begin
    if (mem_we) plru_mem[mem_waddr] <= mem_wdata;
    rd_tree <= plru_mem[cap_set];
  end

  plru_tree_walk u_walk (
    .tree       (rd_tree),
    .op         (cap_op),
    .way        (cap_way),
    .new_tree   (walk_tree),
    .result_way (walk_way)
  );

`ifdef PLRU_STATS_EN
  // Completion counters advance on the response handshake and saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_touch_cnt  <= '0;
      stat_victim_cnt <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (cap_op == PLRU_TOUCH) begin
        if (stat_touch_cnt != 32'hFFFF_FFFF) stat_touch_cnt <= stat_touch_cnt + 32'd1;
      end else begin
        if (stat_victim_cnt != 32'hFFFF_FFFF) stat_victim_cnt <= stat_victim_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_plru_replacement_ctrl.sv
// tb_plru_replacement_ctrl
// Directed and randomised bench for plru_replacement_ctrl. Expected ways
// come from a per-set tree model indexed by level and decided-way prefix.
// Build with PLRU_STATS_EN defined to also check the completion counters.
module tb_plru_replacement_ctrl;

  localparam int TB_SETS   = 16384;
  localparam int TB_LEVELS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [13:0] req_set = '0;
  logic [2:0]  req_way = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [2:0]  rsp_way;
  logic        init_done;
`ifdef PLRU_STATS_EN
  logic [31:0] stat_touch_cnt;
  logic [31:0] stat_victim_cnt;
`endif

  int tests_run = 0;
  int fails = 0;
  int exp_touch = 0;
  int exp_victim = 0;
  bit [6:0] ref_tree [int];

  plru_replacement_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_set        (req_set),
    .req_way        (req_way),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_way        (rsp_way),
`ifdef PLRU_STATS_EN
    .stat_touch_cnt (stat_touch_cnt),
    .stat_victim_cnt(stat_victim_cnt),
`endif
    .init_done      (init_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Level lvl holds nodes (2^lvl - 1) .. (2^(lvl+1) - 2); the node visited
  // is picked by the way bits decided so far. Visited nodes take the way bit.
  function automatic int modelAccess(input bit op, input int set, input int way);
    bit [6:0] t;
    int prefix = 0;
    int node;
    bit dir;
    t = ref_tree.exists(set) ? ref_tree[set] : 7'b0;
    for (int lvl = 0; lvl < TB_LEVELS; lvl++) begin
      node = (1 << lvl) - 1 + prefix;
      if (op) dir = (t[node] == 1'b0);
      else    dir = ((way >> (TB_LEVELS - 1 - lvl)) & 1) != 0;
      t[node] = dir;
      prefix = prefix * 2 + int'(dir);
    end
    ref_tree[set] = t;
    return prefix;
  endfunction

  // Issues one request, waits for its response and completes the handshake
  // (rsp_ready is expected high). Called just after a clock edge.
  task automatic applyStimulus(input bit op, input int set, input int way, output int got, output bit ok);
    int n;
    req_op = op; req_set = 14'(set); req_way = 3'(way); req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    got = int'(rsp_way);
    ok = rsp_valid;
    tick();
    if (ok) begin
      if (op) exp_victim++; else exp_touch++;
    end
  endtask

  task automatic doCheck(input string tag, input bit op, input int set, input int way);
    int got, exp_way;
    bit ok;
    exp_way = modelAccess(op, set, way);
    applyStimulus(op, set, way, got, ok);
    checkOutput({tag, "_rsp_seen"}, 32'(ok), 32'd1);
    checkOutput(tag, 32'(got), 32'(exp_way));
  endtask

  initial begin
    int cycles, n, held, got;
    bit seen;
    int acc [$];

    // Reset values
    repeat (3) tick();
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_way",   32'(rsp_way),   32'd0);
    checkOutput("rst_init_done", 32'(init_done), 32'd0);

    // Sweep length; a VICTIM held pending through the sweep must survive
    rst = 1'b0;
    req_op = 1'b1; req_set = 14'd5; req_valid = 1'b1;
    cycles = 0;
    while (!init_done && cycles < 20000) begin
      tick(); cycles++;
      if (!init_done && req_ready) seen = 1'b1;
    end
    checkOutput("init_cycles", 32'(cycles), 32'(TB_SETS));
    checkOutput("init_req_ready", 32'(req_ready), 32'd1);
    checkOutput("init_no_early_ready", 32'(seen), 32'd0);
    checkOutput("set5_swept", 32'(dut.plru_mem[5]), 32'd0);
    req_valid = 1'b0;

    // Three victims on set 5
    doCheck("victim5_a", 1'b1, 5, 0);
    checkOutput("set5_tree_a", 32'(dut.plru_mem[5]), 32'(7'b1000101));
    doCheck("victim5_b", 1'b1, 5, 0);
    doCheck("victim5_c", 1'b1, 5, 0);

    // Touch then victim on fresh sets
    doCheck("touch9_w7",  1'b0, 9, 7);
    doCheck("victim9",    1'b1, 9, 0);
    doCheck("touch10_w0", 1'b0, 10, 0);
    doCheck("victim10",   1'b1, 10, 0);

    // Back-pressure in RESP; a second request stays pending and unaccepted
    rsp_ready = 1'b0;
    req_op = 1'b1; req_set = 14'd20; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    tick();
    req_set = 14'd21;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    held = int'(rsp_way);
    checkOutput("stall_way", 32'(held), 32'(modelAccess(1'b1, 20, 0)));
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("stall_rsp_way",   32'(rsp_way),   32'(held));
      checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    exp_victim++;
    checkOutput("stall_release_ready", 32'(req_ready), 32'd1);
    checkOutput("stall_release_valid", 32'(rsp_valid), 32'd0);

    // Issue interval with a request held continuously
    req_op = 1'b1; req_set = 14'd40; req_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (req_ready) acc.push_back(c);
      tick();
    end
    req_valid = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    checkOutput("interval_accepts", 32'(acc.size()), 32'd4);
    if (acc.size() >= 3) begin
      checkOutput("interval_0", 32'(acc[1] - acc[0]), 32'd4);
      checkOutput("interval_1", 32'(acc[2] - acc[1]), 32'd4);
    end
    foreach (acc[k]) begin
      got = modelAccess(1'b1, 40, 0);
      exp_victim++;
    end
    doCheck("victim40_after", 1'b1, 40, 0);

    // Random traffic on a small group of sets so updates collide
    for (int i = 0; i < 40; i++) begin
      doCheck("random", 1'($urandom_range(0, 1)), int'($urandom_range(100, 107)), int'($urandom_range(0, 7)));
    end

`ifdef PLRU_STATS_EN
    checkOutput("stat_touch",  stat_touch_cnt,  32'(exp_touch));
    checkOutput("stat_victim", stat_victim_cnt, 32'(exp_victim));
`endif

    // Reset while a VICTIM is in UPDATE: no response, sweep restarts
    doCheck("touch50_w7", 1'b0, 50, 7);
    req_op = 1'b1; req_set = 14'd50; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_init_done", 32'(init_done), 32'd0);
    checkOutput("midrst_rsp_way",   32'(rsp_way),   32'd0);
    tick();
    rst = 1'b0;
    ref_tree.delete();
    exp_touch = 0;
    exp_victim = 0;
    seen = 1'b0;
    cycles = 0;
    while (!init_done && cycles < 20000) begin
      tick(); cycles++;
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("reinit_cycles", 32'(cycles), 32'(TB_SETS));
    checkOutput("reinit_no_rsp", 32'(seen), 32'd0);
    doCheck("victim50_after_rst", 1'b1, 50, 0);

`ifdef PLRU_STATS_EN
    doCheck("st_t0", 1'b0, 60, 3);
    doCheck("st_t1", 1'b0, 61, 4);
    doCheck("st_v0", 1'b1, 60, 0);
    doCheck("st_v1", 1'b1, 61, 0);
    checkOutput("stat_touch_after_rst",  stat_touch_cnt,  32'(exp_touch));
    checkOutput("stat_victim_after_rst", stat_victim_cnt, 32'(exp_victim));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
